// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: one shared tick prescaler drives per-channel
// OFF/ON/BLINK/PULSE state machines, reconfigured through a valid/ready write port.
module led_pattern_gen #(
    parameter int NUM_CH     = 3,
    parameter int PRESCALE   = 2000,
    parameter int PER_W      = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH):0]   cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [PER_W-1:0]          cfg_period,
    output logic                      tick_o,
    output logic [NUM_CH-1:0]         pulse_done,
    output logic [NUM_CH-1:0]         led_o
);

    localparam int                CH_W    = $clog2(NUM_CH) + 1;
    localparam int                PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [NUM_CH-1:0] POL     = {NUM_CH{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_BLINK = 2'd2,
        M_PULSE = 2'd3
    } mode_t;

    logic [PS_W-1:0]  pre_cnt;
    mode_t            mode_q   [NUM_CH];
    mode_t            mode_d   [NUM_CH];
    logic [PER_W-1:0] per_q    [NUM_CH];
    logic [PER_W-1:0] per_d    [NUM_CH];
    logic [PER_W-1:0] phase_q  [NUM_CH];
    logic [PER_W-1:0] phase_d  [NUM_CH];
    logic [NUM_CH-1:0] lit_q;
    logic [NUM_CH-1:0] lit_d;
    logic [NUM_CH-1:0] done_d;
    logic              wr_en;
    logic [PER_W-1:0]  per_in;

    // A write to a channel takes priority over a coincident tick on that channel.
    always_comb begin
        wr_en  = cfg_valid && cfg_ready;
        per_in = (cfg_period == '0) ? PER_W'(1) : cfg_period;
        lit_d  = lit_q;
        done_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]  = mode_q[i];
            per_d[i]   = per_q[i];
            phase_d[i] = phase_q[i];
            if (wr_en && (cfg_ch == CH_W'(i))) begin
                mode_d[i]  = mode_t'(cfg_mode);
                per_d[i]   = per_in;
                phase_d[i] = '0;
                lit_d[i]   = (cfg_mode != M_OFF);
            end else if (tick_o) begin
                case (mode_q[i])
                    M_BLINK: begin
                        if (phase_q[i] == per_q[i] - PER_W'(1)) begin
                            phase_d[i] = '0;
                            lit_d[i]   = ~lit_q[i];
                        end else begin
                            phase_d[i] = phase_q[i] + PER_W'(1);
                        end
                    end
                    M_PULSE: begin
                        if (phase_q[i] == per_q[i] - PER_W'(1)) begin
                            phase_d[i] = '0;
                            lit_d[i]   = 1'b0;
                            mode_d[i]  = M_OFF;
                            done_d[i]  = 1'b1;
                        end else begin
                            phase_d[i] = phase_q[i] + PER_W'(1);
                        end
                    end
                    default: phase_d[i] = '0;
                endcase
            end
        end
    end

    // Prescaler and channel state; led_o is its own register so the pins never glitch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_cnt    <= '0;
            tick_o     <= 1'b0;
            cfg_ready  <= 1'b0;
            pulse_done <= '0;
            lit_q      <= '0;
            led_o      <= POL;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]  <= M_OFF;
                per_q[i]   <= PER_W'(1);
                phase_q[i] <= '0;
            end
        end else begin
            pre_cnt    <= (pre_cnt == PS_LAST) ? '0 : pre_cnt + PS_W'(1);
            tick_o     <= (pre_cnt == PS_LAST);
            cfg_ready  <= 1'b1;
            pulse_done <= done_d;
            lit_q      <= lit_d;
            led_o      <= lit_d ^ POL;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]  <= mode_d[i];
                per_q[i]   <= per_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

endmodule
